// File: rtl/prog_load_ctrl.sv
// Host byte-command loader: packs host bytes into memory words, services byte
// reads through one memory port and owns the core run enable (BYTES = 2^n, n >= 1).
module prog_load_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int WORD_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int RD_LAT     = 1,
  localparam int BYTES = WORD_W / 8,
  localparam int OFF_W = $clog2(BYTES),
  localparam int MA_W  = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        data_in,
  input  logic              start_signal,
  output logic              cmd_done,
  output logic              cmd_err,
  output logic [7:0]        data_out,
  output logic              cpu_run,
  output logic              mem_we,
  output logic              mem_re,
  output logic [MA_W-1:0]   mem_addr,
  output logic [BYTES-1:0]  mem_be,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_RUN   = 3'd3;
  localparam logic [2:0] CMD_HALT  = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_RD_REQ, S_RD_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              cv_q, cv_d, cv_prev_q, cv_prev_d, cv_edge_q, cv_edge_d;
  logic              st_q, st_d, st_prev_q, st_prev_d, st_edge_q, st_edge_d;
  logic [2:0]        cmd_p_q, cmd_p_d;
  logic [ADDR_W-1:0] addr_p_q, addr_p_d;
  logic [7:0]        din_p_q, din_p_d;
  logic [2:0]        op_cmd_q, op_cmd_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [7:0]        op_din_q, op_din_d;
  logic              err_q, err_d;
  logic              need_store_q, need_store_d;
  logic              run_pend_q, run_pend_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [WORD_W-1:0] pend_word_q, pend_word_d;
  logic [BYTES-1:0]  pend_be_q, pend_be_d;
  logic [MA_W-1:0]   pend_waddr_q, pend_waddr_d;
  logic              cpu_run_q, cpu_run_d;
  logic [7:0]        data_out_q, data_out_d;

  logic [ADDR_W-1:0] s_addr;
  logic [7:0]        s_din;
  logic [OFF_W-1:0]  s_off, s_lane;
  logic [MA_W-1:0]   s_waddr;
  logic              pending, start, store;
  logic [2:0]        start_cmd;

  // While idle the freshly captured host fields are decoded; afterwards the
  // latched operation is, so a byte deferred behind a flush keeps its address.
  always_comb begin
    s_addr  = (state_q == S_IDLE) ? addr_p_q : op_addr_q;
    s_din   = (state_q == S_IDLE) ? din_p_q  : op_din_q;
    s_off   = s_addr[OFF_W-1:0];
    s_lane  = BIG_ENDIAN ? ~s_off : s_off;
    s_waddr = s_addr[ADDR_W-1:OFF_W];
    pending = |pend_be_q;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    cv_d         = cmd_valid;
    cv_prev_d    = cv_q;
    cv_edge_d    = cv_q & ~cv_prev_q;
    st_d         = start_signal;
    st_prev_d    = st_q;
    st_edge_d    = st_q & ~st_prev_q;
    cmd_p_d      = cmd;
    addr_p_d     = address;
    din_p_d      = data_in;
    state_d      = state_q;
    op_cmd_d     = op_cmd_q;
    op_addr_d    = op_addr_q;
    op_din_d     = op_din_q;
    err_d        = err_q;
    need_store_d = need_store_q;
    run_pend_d   = run_pend_q;
    wait_cnt_d   = wait_cnt_q;
    pend_word_d  = pend_word_q;
    pend_be_d    = pend_be_q;
    pend_waddr_d = pend_waddr_q;
    cpu_run_d    = cpu_run_q;
    data_out_d   = data_out_q;
    start        = 1'b0;
    start_cmd    = CMD_NOP;
    store        = 1'b0;
    cmd_done     = 1'b0;
    cmd_err      = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = '0;
    mem_be       = '0;
    mem_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        if (cv_edge_q) begin
          start      = 1'b1;
          start_cmd  = cmd_p_q;
          op_addr_d  = addr_p_q;
          op_din_d   = din_p_q;
          // A start edge coinciding with a host command is replayed once idle again.
          run_pend_d = run_pend_q | st_edge_q;
        end else if (st_edge_q || run_pend_q) begin
          start      = 1'b1;
          start_cmd  = CMD_RUN;
          run_pend_d = 1'b0;
        end
        if (start) begin
          op_cmd_d     = start_cmd;
          err_d        = 1'b0;
          need_store_d = 1'b0;
          state_d      = S_DONE;
          case (start_cmd)
            CMD_NOP: state_d = S_DONE;
            CMD_WRITE: begin
              if (cpu_run_q) begin
                err_d = 1'b1;
              end else if (pending && (pend_waddr_q != s_waddr)) begin
                need_store_d = 1'b1;
                state_d      = S_FLUSH;
              end else begin
                store = 1'b1;
              end
            end
            CMD_READ: begin
              if (cpu_run_q) err_d   = 1'b1;
              else           state_d = pending ? S_FLUSH : S_RD_REQ;
            end
            CMD_RUN: begin
              if (!cpu_run_q) begin
                if (pending) state_d   = S_FLUSH;
                else         cpu_run_d = 1'b1;
              end
            end
            CMD_HALT: cpu_run_d = 1'b0;
            default:  err_d     = 1'b1;
          endcase
        end
      end

      S_FLUSH: begin
        mem_we      = 1'b1;
        mem_addr    = pend_waddr_q;
        mem_be      = pend_be_q;
        mem_wdata   = pend_word_q;
        pend_be_d   = '0;
        pend_word_d = '0;
        case (op_cmd_q)
          CMD_WRITE: begin
            if (need_store_q) begin
              need_store_d = 1'b0;
              store        = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
          CMD_READ: state_d = S_RD_REQ;
          default: begin
            cpu_run_d = 1'b1;
            state_d   = S_DONE;
          end
        endcase
      end

      S_RD_REQ: begin
        mem_re     = 1'b1;
        mem_addr   = s_waddr;
        wait_cnt_d = 2'd0;
        state_d    = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (wait_cnt_q == 2'(RD_LAT - 1)) begin
          data_out_d = mem_rdata[{s_lane, 3'b000} +: 8];
          state_d    = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end

      S_DONE: begin
        cmd_done = 1'b1;
        cmd_err  = err_q;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Merging a byte into the pending word; the last byte offset forces a write-out.
    if (store) begin
      pend_word_d[{s_lane, 3'b000} +: 8] = s_din;
      pend_be_d[s_lane]                  = 1'b1;
      pend_waddr_d                       = s_waddr;
      state_d                            = (&s_off) ? S_FLUSH : S_DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears the
  // pending word so bytes buffered before a reset are never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cv_q         <= 1'b0;
      cv_prev_q    <= 1'b0;
      cv_edge_q    <= 1'b0;
      st_q         <= 1'b0;
      st_prev_q    <= 1'b0;
      st_edge_q    <= 1'b0;
      cmd_p_q      <= '0;
      addr_p_q     <= '0;
      din_p_q      <= '0;
      op_cmd_q     <= '0;
      op_addr_q    <= '0;
      op_din_q     <= '0;
      err_q        <= 1'b0;
      need_store_q <= 1'b0;
      run_pend_q   <= 1'b0;
      wait_cnt_q   <= '0;
      pend_word_q  <= '0;
      pend_be_q    <= '0;
      pend_waddr_q <= '0;
      cpu_run_q    <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      cv_q         <= cv_d;
      cv_prev_q    <= cv_prev_d;
      cv_edge_q    <= cv_edge_d;
      st_q         <= st_d;
      st_prev_q    <= st_prev_d;
      st_edge_q    <= st_edge_d;
      cmd_p_q      <= cmd_p_d;
      addr_p_q     <= addr_p_d;
      din_p_q      <= din_p_d;
      op_cmd_q     <= op_cmd_d;
      op_addr_q    <= op_addr_d;
      op_din_q     <= op_din_d;
      err_q        <= err_d;
      need_store_q <= need_store_d;
      run_pend_q   <= run_pend_d;
      wait_cnt_q   <= wait_cnt_d;
      pend_word_q  <= pend_word_d;
      pend_be_q    <= pend_be_d;
      pend_waddr_q <= pend_waddr_d;
      cpu_run_q    <= cpu_run_d;
      data_out_q   <= data_out_d;
    end
  end

  assign cpu_run  = cpu_run_q;
  assign data_out = data_out_q;

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Host-side program/data loader for the RISC-V core. Replaces per-byte direct memory pokes.
- Accepts byte-wide host commands (cmd / cmd_valid / address / data_in) and packs bytes into memory words with byte enables.
- Issues word writes and reads to one instruction/data memory port, returns read bytes on data_out, and owns the core run control (cpu_run).

Parameters:
- ADDR_W, 8, host byte-address width.
- WORD_W, 32, memory word width; must be a multiple of 8; BYTES = WORD_W/8.
- BIG_ENDIAN, 1, 1: byte offset 0 is the MS byte of the word; 0: byte offset 0 is the LS byte.
- RD_LAT, 1, memory read latency in cycles, 1..4.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cmd  in  3  command: 0 NOP, 1 READ, 2 WRITE, 3 RUN, 4 HALT; others illegal.
- cmd_valid  in  1  level; command accepted on its 0->1 edge only.
- address  in  ADDR_W  host byte address.
- data_in  in  8  write byte.
- start_signal  in  1  level; 0->1 edge equals a RUN command.
- cmd_done  out  1  one-cycle pulse when the accepted command completes.
- cmd_err  out  1  one-cycle pulse, coincident with cmd_done, on a rejected command.
- data_out  out  8  READ result; held until the next READ completes.
- cpu_run  out  1  core run enable.
- mem_we  out  1  word write strobe.
- mem_re  out  1  word read strobe.
- mem_addr  out  ADDR_W-log2(BYTES)  word address.
- mem_be  out  BYTES  byte enables for mem_we.
- mem_wdata  out  WORD_W  write word.
- mem_rdata  in  WORD_W  valid RD_LAT cycles after mem_re.

Behaviour:
- Reset:
  - All outputs are 0; FSM in IDLE; pending buffer empty.
  - Reset mid-operation discards any pending bytes without writing them.
- Command acceptance:
  - cmd_valid and start_signal are each registered; an edge is detected one cycle after the input rises.
  - A command is accepted only in IDLE.
  - Edges that arrive while busy are dropped; no queueing.
- States: IDLE, FLUSH, RD_REQ, RD_WAIT, DONE.
- WRITE:
  - off = address mod BYTES; lane = off when BIG_ENDIAN=0, else BYTES-1-off.
  - If a word is pending and its word address differs from the new one, go to FLUSH first. The new byte is captured after the flush.
  - Store the byte into the pending word and set pend_be[lane].
  - If off == BYTES-1, FLUSH; otherwise go to DONE.
- FLUSH:
  - One cycle with mem_we=1, mem_be=pend_be, mem_wdata=pend_word; then clear pend_be.
  - Partial words are written with partial mem_be.
- READ:
  - If anything is pending, FLUSH first.
  - RD_REQ: mem_re=1 for 1 cycle.
  - RD_WAIT: lasts RD_LAT cycles, then latch the selected lane into data_out and go to DONE.
- RUN:
  - Flush pending bytes, then set cpu_run=1 and go to DONE.
  - If cpu_run is already 1: no-op, done without error.
- HALT: clear cpu_run, then DONE.
- Rejected commands (done + err, no memory access):
  - WRITE while cpu_run=1.
  - READ while cpu_run=1.
  - Illegal cmd value.
- NOP: done without error.
- DONE: cmd_done=1 for exactly one cycle, then IDLE.
- Latency from cmd_valid rising to cmd_done:
  - WRITE without flush: 3 cycles.
  - WRITE that completes a word: 4 cycles.
  - READ: 4+RD_LAT cycles, plus 1 if a flush is needed.
- Simultaneous cmd_valid edge and start_signal edge: the cmd_valid command is taken, and RUN is retried when the FSM next reaches IDLE (one-deep latch).
- Address wrap: no special case; ADDR_W-bit address arithmetic.

Test Plan:
- Write 0x00,0x50,0x01,0x13 to addresses 0..3 (BIG_ENDIAN=1): exactly one mem_we, mem_addr=0, mem_be=4'hF, mem_wdata=32'h00500113; four cmd_done pulses, no cmd_err.
- Write address 4 = 0xAA, then address 9 = 0x55: flush at mem_addr=1 with mem_be=4'b1000, wdata[31:24]=0xAA, before byte 9 is buffered.
- Write address 6 = 0x3C, then READ address 6: partial flush with mem_be=4'b0010 precedes mem_re; data_out=0x3C; cmd_done at 5+RD_LAT cycles.
- Load 14 words, then raise start_signal: cpu_run=1, no extra mem_we. Then WRITE address 0: cmd_done and cmd_err pulse, no mem_we. Then HALT: cpu_run=0.
- Hold cmd_valid high for 5 cycles with cmd=2: exactly one acceptance and one cmd_done. Also: cmd=7 -> cmd_err.
- Assert rst after bytes 0..2 are written, then write byte 3 after reset: mem_we with mem_be=4'b0001 only; bytes 0..2 are not written.
